sprite_queue: RTL and testbench
===============================

// Module: sprite_queue
// PURPOSE
//  First-word-fall-through draw queue sitting directly upstream of the sprite
//  driver's distributor. The command interface (SPI/CPU side) pushes sprite
//  draw records {id,x,y,scale}. The distributor pops them with a one-cycle
//  dequeue pulse. The queue is flushed at each frame start so stale draws
//  never leak into the next frame.
// PARAMETERS
//  DEPTH     16   entries; power of two, >= 2
//  SCREEN_W  800  visible width in pixels (used only with SPRITE_QUEUE_CLIP_EN)
//  SCREEN_H  600  visible height in pixels (used only with SPRITE_QUEUE_CLIP_EN)
// PORTS
//  clock                       in   1   system clock
//  reset_n                     in   1   async active-low reset
//  flush                       in   1   sync clear of all entries (frame start)
//  enq_valid                   in   1   producer has a record
//  enq_ready                   out  1   queue can accept (= !full)
//  enq_sprite_id               in   8   sprite index
//  enq_sprite_x                in   16  x position (unsigned)
//  enq_sprite_y                in   16  y position (unsigned)
//  enq_sprite_scale            in   8   scale code
//  sprite_queue_dequeue        in   1   pop head; one-cycle pulse
//  sprite_queue_is_empty       out  1   no valid head
//  sprite_queue_sprite_id      out  8   head record id
//  sprite_queue_sprite_x       out  16  head record x
//  sprite_queue_sprite_y       out  16  head record y
//  sprite_queue_sprite_scale   out  8   head record scale
//  count                       out  $clog2(DEPTH)+1  occupied entries
//  overflow                    out  1   sticky: enq_valid seen while full
//  clip_drop                   out  1   one-cycle pulse: record discarded (CLIP_EN only)
// BEHAVIOUR
//  - Reset (reset_n=0, async): wr_ptr=rd_ptr=0, count=0, is_empty=1,
//    enq_ready=1, overflow=0, clip_drop=0. Head data outputs read 0.
//    Storage array is not reset.
//  - Enqueue fires on a clock edge with enq_valid && enq_ready. It writes
//    mem[wr_ptr] and advances wr_ptr mod DEPTH.
//  - Dequeue fires on an edge with sprite_queue_dequeue && !is_empty and
//    advances rd_ptr mod DEPTH. A dequeue while empty is ignored with no
//    pointer change.
//  - Head outputs are combinational from mem[rd_ptr], i.e. FWFT.
//    Latency: a record enqueued into an empty queue at edge N is visible with
//    is_empty=0 after edge N, so the consumer can dequeue at edge N+1.
//  - The new head is valid the cycle after a dequeue edge. This matches the
//    distributor's pulse-then-wait pattern.
//  - count, is_empty, and enq_ready are registered/derived from count:
//    is_empty=(count==0), enq_ready=(count!=DEPTH).
//  - Simultaneous enq+deq when 0<count<DEPTH: both fire and count is
//    unchanged.
//  - When full: enq_ready=0 even if a dequeue occurs the same cycle (no
//    pass-through). The dequeue still fires.
//  - When empty: an enq+deq in the same cycle enqueues only; the dequeue is
//    ignored.
//  - overflow is set on any edge with enq_valid && !enq_ready. It holds until
//    flush or reset.
//  - flush has priority over enq and deq in the same cycle. It sets pointers=0,
//    count=0, overflow=0, and the same-cycle enqueue is discarded.
//    enq_ready remains 1 during flush.
//  - Pointers use $clog2(DEPTH) bits and wrap naturally. count is one bit
//    wider so that full and empty are distinct.
//  - Records are stored as-is; no arithmetic is applied to x, y, or scale.
// CONFIGURATION
//  SPRITE_QUEUE_CLIP_EN defined:
//    - An accepted record with x >= SCREEN_W or y >= SCREEN_H (unsigned
//      compare) is consumed (handshake completes) but not written.
//    - Pointers and count are unchanged for that record.
//    - clip_drop pulses high for the cycle following the accepting edge.
//    - When full, enq_ready=0 applies regardless of coordinates.
//  SPRITE_QUEUE_CLIP_EN undefined:
//    - All accepted records are stored.
//    - clip_drop is tied to 0.
//    - SCREEN_W and SCREEN_H are unused.
// TESTING
//  1 Reset then idle:
//    -> is_empty=1, count=0, enq_ready=1, overflow=0.
//    A dequeue pulse leaves count=0.
//  2 Enqueue {id=3,x=100,y=50,scale=8}:
//    -> next cycle is_empty=0, head=={3,100,50,8}.
//    Dequeue pulse -> next cycle is_empty=1.
//  3 Enqueue 16 records with ids 0..15 (DEPTH=16):
//    -> count=16, enq_ready=0.
//    A 17th enq_valid -> overflow=1 and the record is not stored.
//    Dequeue all -> ids 0..15 are returned in order.
//  4 Wrap test, 8 entries queued:
//    Drive enq+deq each cycle for 40 cycles -> count stays 8 and the FIFO
//    order is intact across the pointer wrap.
//  5 Queue holding 5 entries with overflow=1:
//    Assert flush alongside enq_valid and dequeue -> next cycle count=0,
//    is_empty=1, overflow=0, and nothing is stored.
//  6 CLIP_EN build:
//    Enqueue x=800,y=10 -> clip_drop=1, count=0.
//    Enqueue x=799,y=599 -> stored, count=1.
//    Non-CLIP build: both records are stored, count=2.

Source files
------------

// File: rtl/sprite_queue.sv
// First-word-fall-through draw queue feeding the sprite distributor; flushed at frame start.
// Optional build macro: SPRITE_QUEUE_CLIP_EN drops records whose position lies off screen.
module sprite_queue #(
    parameter int DEPTH    = 16,
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 600
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [7:0]                 enq_sprite_id,
    input  logic [15:0]                enq_sprite_x,
    input  logic [15:0]                enq_sprite_y,
    input  logic [7:0]                 enq_sprite_scale,
    input  logic                       sprite_queue_dequeue,
    output logic                       sprite_queue_is_empty,
    output logic [7:0]                 sprite_queue_sprite_id,
    output logic [15:0]                sprite_queue_sprite_x,
    output logic [15:0]                sprite_queue_sprite_y,
    output logic [7:0]                 sprite_queue_sprite_scale,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       clip_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 48;

    // Elaboration-time sanity checks on the configuration.
    if ((DEPTH < 2) || ((1 << PTR_W) != DEPTH)) begin : g_bad_depth
        $error("sprite_queue: DEPTH must be a power of two >= 2");
    end
    if ((SCREEN_W < 1) || (SCREEN_H < 1) || (SCREEN_W > 65536) || (SCREEN_H > 65536)) begin : g_bad_screen
        $error("sprite_queue: SCREEN_W/SCREEN_H out of range");
    end

    logic [REC_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             clip_drop_reg, clip_drop_next;

    logic             enq_fire;
    logic             deq_fire;
    logic             wr_en;
    logic             in_range;
    logic [REC_W-1:0] wr_data;
    logic [REC_W-1:0] head_data;

    assign sprite_queue_is_empty = (count_reg == '0);
    assign enq_ready             = (count_reg != CNT_W'(DEPTH));
    assign count                 = count_reg;
    assign overflow              = overflow_reg;

    assign wr_data  = {enq_sprite_id, enq_sprite_x, enq_sprite_y, enq_sprite_scale};

    // flush wins over both sides of the handshake in the same cycle.
    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = sprite_queue_dequeue && !sprite_queue_is_empty && !flush;

`ifdef SPRITE_QUEUE_CLIP_EN
    assign in_range  = ({16'd0, enq_sprite_x} < 32'(SCREEN_W)) &&
                       ({16'd0, enq_sprite_y} < 32'(SCREEN_H));
    assign wr_en     = enq_fire && in_range;
    assign clip_drop = clip_drop_reg;
`else
    assign in_range  = 1'b1;
    assign wr_en     = enq_fire && in_range;
    assign clip_drop = 1'b0;
`endif

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        clip_drop_next = 1'b0;

        if (flush) begin
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
            overflow_next = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            case ({wr_en, deq_fire})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
            if (enq_valid && !enq_ready) begin
                overflow_next = 1'b1;
            end
            clip_drop_next = enq_fire && !in_range;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            clip_drop_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            clip_drop_reg <= clip_drop_next;
        end
    end

    // Storage is deliberately left out of reset so it can map to distributed RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Head is masked while empty so stale or uninitialised storage never shows.
    assign head_data = sprite_queue_is_empty ? '0 : mem[rd_ptr_reg];

    assign sprite_queue_sprite_id    = head_data[47:40];
    assign sprite_queue_sprite_x     = head_data[39:24];
    assign sprite_queue_sprite_y     = head_data[23:8];
    assign sprite_queue_sprite_scale = head_data[7:0];

endmodule

// File: tb/tb_sprite_queue.sv
// Self-checking bench for sprite_queue with a scoreboard queue of expected head records.
module tb_sprite_queue;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [7:0]  enq_sprite_id;
    logic [15:0] enq_sprite_x;
    logic [15:0] enq_sprite_y;
    logic [7:0]  enq_sprite_scale;
    logic        sprite_queue_dequeue;
    logic        sprite_queue_is_empty;
    logic [7:0]  sprite_queue_sprite_id;
    logic [15:0] sprite_queue_sprite_x;
    logic [15:0] sprite_queue_sprite_y;
    logic [7:0]  sprite_queue_sprite_scale;
    logic [4:0]  count;
    logic        overflow;
    logic        clip_drop;

    rec_t head;
    rec_t sb[$];
    rec_t exp_rec;
    int   checks   = 0;
    int   failures = 0;

    assign head = {sprite_queue_sprite_id, sprite_queue_sprite_x,
                   sprite_queue_sprite_y, sprite_queue_sprite_scale};

    always #5 clock = ~clock;

    sprite_queue #(.DEPTH(16), .SCREEN_W(800), .SCREEN_H(600)) dut (
        .clock                     (clock),
        .reset_n                   (reset_n),
        .flush                     (flush),
        .enq_valid                 (enq_valid),
        .enq_ready                 (enq_ready),
        .enq_sprite_id             (enq_sprite_id),
        .enq_sprite_x              (enq_sprite_x),
        .enq_sprite_y              (enq_sprite_y),
        .enq_sprite_scale          (enq_sprite_scale),
        .sprite_queue_dequeue      (sprite_queue_dequeue),
        .sprite_queue_is_empty     (sprite_queue_is_empty),
        .sprite_queue_sprite_id    (sprite_queue_sprite_id),
        .sprite_queue_sprite_x     (sprite_queue_sprite_x),
        .sprite_queue_sprite_y     (sprite_queue_sprite_y),
        .sprite_queue_sprite_scale (sprite_queue_sprite_scale),
        .count                     (count),
        .overflow                  (overflow),
        .clip_drop                 (clip_drop)
    );

    // Drive one cycle of stimulus, then return 1 time unit after the edge.
    task automatic step(input logic ev, input rec_t r, input logic dq, input logic fl);
        enq_valid            = ev;
        enq_sprite_id        = r.id;
        enq_sprite_x         = r.x;
        enq_sprite_y         = r.y;
        enq_sprite_scale     = r.scale;
        sprite_queue_dequeue = dq;
        flush                = fl;
        @(posedge clock);
        #1;
        enq_valid            = 1'b0;
        sprite_queue_dequeue = 1'b0;
        flush                = 1'b0;
    endtask

    task automatic test_reset();
        rec_t nul;
        nul = '0;
        reset_n = 1'b0;
        step(1'b0, nul, 1'b0, 1'b0);
        checks++; if (sprite_queue_is_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", sprite_queue_is_empty); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", enq_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (clip_drop !== 1'b0) begin failures++; $display("FAIL reset_clip_drop got=%b exp=0", clip_drop); end
        checks++; if (head !== rec_t'(0)) begin failures++; $display("FAIL reset_head got=%h exp=0", head); end
        reset_n = 1'b1;
        step(1'b0, nul, 1'b0, 1'b0);
        step(1'b0, nul, 1'b1, 1'b0);
        checks++; if (count !== 5'd0 || sprite_queue_is_empty !== 1'b1) begin failures++; $display("FAIL idle_dequeue count=%0d empty=%b exp count=0 empty=1", count, sprite_queue_is_empty); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        rec_t r;
        r = '{id: 8'd3, x: 16'd100, y: 16'd50, scale: 8'd8};
        step(1'b1, r, 1'b0, 1'b0);
        sb.push_back(r);
        checks++; if (sprite_queue_is_empty !== 1'b0) begin failures++; $display("FAIL single_not_empty got=%b exp=0", sprite_queue_is_empty); end
        exp_rec = sb.pop_front();
        checks++; if (head !== exp_rec) begin failures++; $display("FAIL single_head got=%h exp=%h", head, exp_rec); end
        step(1'b0, r, 1'b1, 1'b0);
        checks++; if (sprite_queue_is_empty !== 1'b1) begin failures++; $display("FAIL single_empty_after_deq got=%b exp=1", sprite_queue_is_empty); end
        $display("test_single done");
    endtask

    task automatic test_empty_simul();
        rec_t r;
        r = '{id: 8'h5A, x: 16'd7, y: 16'd9, scale: 8'd1};
        step(1'b1, r, 1'b1, 1'b0);
        sb.push_back(r);
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL empty_simul_count got=%0d exp=1", count); end
        exp_rec = sb.pop_front();
        checks++; if (head !== exp_rec) begin failures++; $display("FAIL empty_simul_head got=%h exp=%h", head, exp_rec); end
        step(1'b0, r, 1'b1, 1'b0);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL empty_simul_drain got=%0d exp=0", count); end
        $display("test_empty_simul done");
    endtask

    task automatic test_full();
        rec_t r;
        for (int i = 0; i < 16; i++) begin
            r = '{id: 8'(i), x: 16'(i * 37 + 1), y: 16'(i * 11 + 2), scale: 8'(i + 16)};
            step(1'b1, r, 1'b0, 1'b0);
            sb.push_back(r);
        end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL full_count got=%0d exp=16", count); end
        checks++; if (enq_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", enq_ready); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_no_overflow_yet got=%b exp=0", overflow); end
        r = '{id: 8'hAA, x: 16'hBEEF, y: 16'h1234, scale: 8'h55};
        step(1'b1, r, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL overflow_count got=%0d exp=16", count); end
        // Full with simultaneous dequeue: no pass-through, dequeue still fires.
        exp_rec = sb.pop_front();
        checks++; if (head !== exp_rec) begin failures++; $display("FAIL full_deq_head got=%h exp=%h", head, exp_rec); end
        step(1'b1, r, 1'b1, 1'b0);
        checks++; if (count !== 5'd15) begin failures++; $display("FAIL full_enq_deq_count got=%0d exp=15", count); end
        for (int i = 0; i < 15; i++) begin
            if (sb.size() == 0) begin
                checks++; failures++; $display("FAIL full_drain_sb got=empty exp=entry");
                break;
            end
            exp_rec = sb.pop_front();
            checks++; if (head !== exp_rec) begin failures++; $display("FAIL full_drain_head[%0d] got=%h exp=%h", i, head, exp_rec); end
            step(1'b0, r, 1'b1, 1'b0);
        end
        checks++; if (sprite_queue_is_empty !== 1'b1) begin failures++; $display("FAIL full_drained_empty got=%b exp=1", sprite_queue_is_empty); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
        $display("test_full done");
    endtask

    task automatic test_flush();
        rec_t r;
        for (int i = 0; i < 5; i++) begin
            r = '{id: 8'(i + 40), x: 16'(i), y: 16'(i), scale: 8'(i)};
            step(1'b1, r, 1'b0, 1'b0);
        end
        checks++; if (count !== 5'd5 || overflow !== 1'b1) begin failures++; $display("FAIL flush_setup count=%0d ovf=%b exp count=5 ovf=1", count, overflow); end
        r = '{id: 8'hEE, x: 16'd1, y: 16'd1, scale: 8'd1};
        step(1'b1, r, 1'b1, 1'b1);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (sprite_queue_is_empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", sprite_queue_is_empty); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
        checks++; if (enq_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b exp=1", enq_ready); end
        step(1'b0, r, 1'b0, 1'b0);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_nothing_stored got=%0d exp=0", count); end
        $display("test_flush done");
    endtask

    task automatic test_wrap();
        rec_t r;
        for (int i = 0; i < 8; i++) begin
            r = '{id: 8'(100 + i), x: 16'(i * 3), y: 16'(i * 5), scale: 8'(i)};
            step(1'b1, r, 1'b0, 1'b0);
            sb.push_back(r);
        end
        for (int k = 0; k < 40; k++) begin
            r = '{id: 8'(150 + k), x: 16'(1000 + k), y: 16'(2000 + k), scale: 8'(k ^ 8'h3C)};
            exp_rec = sb.pop_front();
            checks++; if (head !== exp_rec) begin failures++; $display("FAIL wrap_head[%0d] got=%h exp=%h", k, head, exp_rec); end
            step(1'b1, r, 1'b1, 1'b0);
            sb.push_back(r);
            checks++; if (count !== 5'd8) begin failures++; $display("FAIL wrap_count[%0d] got=%0d exp=8", k, count); end
        end
        for (int i = 0; i < 8; i++) begin
            exp_rec = sb.pop_front();
            checks++; if (head !== exp_rec) begin failures++; $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, head, exp_rec); end
            step(1'b0, r, 1'b1, 1'b0);
        end
        checks++; if (sprite_queue_is_empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", sprite_queue_is_empty); end
        $display("test_wrap done");
    endtask

    task automatic test_clip();
        rec_t r;
        r = '{id: 8'd1, x: 16'd800, y: 16'd10, scale: 8'd2};
        step(1'b1, r, 1'b0, 1'b0);
`ifdef SPRITE_QUEUE_CLIP_EN
        checks++; if (clip_drop !== 1'b1) begin failures++; $display("FAIL clip_drop_pulse got=%b exp=1", clip_drop); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL clip_count got=%0d exp=0", count); end
`else
        sb.push_back(r);
        checks++; if (clip_drop !== 1'b0) begin failures++; $display("FAIL clip_drop_tied got=%b exp=0", clip_drop); end
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL noclip_count got=%0d exp=1", count); end
`endif
        r = '{id: 8'd2, x: 16'd799, y: 16'd599, scale: 8'd3};
        step(1'b1, r, 1'b0, 1'b0);
        sb.push_back(r);
        checks++; if (clip_drop !== 1'b0) begin failures++; $display("FAIL clip_drop_inrange got=%b exp=0", clip_drop); end
`ifdef SPRITE_QUEUE_CLIP_EN
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL clip_store_count got=%0d exp=1", count); end
`else
        checks++; if (count !== 5'd2) begin failures++; $display("FAIL noclip_store_count got=%0d exp=2", count); end
`endif
        while (sb.size() > 0) begin
            exp_rec = sb.pop_front();
            checks++; if (head !== exp_rec) begin failures++; $display("FAIL clip_drain_head got=%h exp=%h", head, exp_rec); end
            step(1'b0, r, 1'b1, 1'b0);
        end
        checks++; if (sprite_queue_is_empty !== 1'b1) begin failures++; $display("FAIL clip_final_empty got=%b exp=1", sprite_queue_is_empty); end
        $display("test_clip done");
    endtask

    initial begin
        reset_n              = 1'b0;
        flush                = 1'b0;
        enq_valid            = 1'b0;
        sprite_queue_dequeue = 1'b0;
        enq_sprite_id        = '0;
        enq_sprite_x         = '0;
        enq_sprite_y         = '0;
        enq_sprite_scale     = '0;
        #2;
        test_reset();
        test_single();
        test_empty_simul();
        test_full();
        test_flush();
        test_wrap();
        test_clip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
